// File: rtl/pmp_pkg.sv
// Shared types and constants for the PMP dreq/drdy byte-handshake initiator.
package pmp_pkg;

    // Width of the PMP data bus.
    localparam int unsigned PMP_DATA_W = 8;

    // Default depth of the pmp_drdy synchronizer (never below 2).
    localparam int unsigned PMP_SYNC_STAGES = 2;

    // Burst reader FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StReq,
        StRel,
        StHold
    } pmp_rd_state_t;

    // States in which the FSM waits on the responder and the timeout counter runs.
    function automatic logic is_wait_state(input pmp_rd_state_t st);
        return (st == StPre) || (st == StReq) || (st == StRel);
    endfunction

endpackage

// File: rtl/pmp_sync.sv
// Single-bit multi-flop synchronizer with asynchronous reset to 0.
module pmp_sync
    import pmp_pkg::*;
#(
    parameter int unsigned STAGES = PMP_SYNC_STAGES
) (
    input  logic sys_clock,
    input  logic sys_reset,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/pmp_burst_reader.sv
// PMP dreq/drdy burst reader: requests bytes one at a time from a responder and
// hands each captured byte to a valid/ready stream.
module pmp_burst_reader
    import pmp_pkg::*;
#(
    parameter int unsigned BURST_MAX      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned SYNC_STAGES    = PMP_SYNC_STAGES
) (
    input  logic                             sys_clock,
    input  logic                             sys_reset,
    input  logic                             start,
    input  logic [$clog2(BURST_MAX+1)-1:0]   burst_len,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout_err,
    output logic [$clog2(BURST_MAX+1)-1:0]   bytes_read,
    output logic                             pmp_dreq,
    input  logic                             pmp_drdy,
    input  logic [PMP_DATA_W-1:0]            pmp_d,
    output logic [PMP_DATA_W-1:0]            byte_data,
    output logic                             byte_valid,
    input  logic                             byte_ready
);

    localparam int unsigned LEN_W = $clog2(BURST_MAX + 1);
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(BURST_MAX);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    pmp_rd_state_t         state_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      bytes_q;
    logic [TMO_W-1:0]      wait_q;
    logic [PMP_DATA_W-1:0] data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  terr_q;
    logic                  dreq_q;
    logic                  valid_q;

    logic                  drdy_s;
    logic                  waiting;
    logic                  advance;
    logic                  timed_out;
    logic [LEN_W-1:0]      count_inc;
    logic [LEN_W-1:0]      len_in;

    pmp_sync #(
        .STAGES (SYNC_STAGES)
    ) u_drdy_sync (
        .sys_clock (sys_clock),
        .sys_reset (sys_reset),
        .async_in  (pmp_drdy),
        .sync_out  (drdy_s)
    );

    // Lengths above BURST_MAX are representable on the port; treat them as BURST_MAX.
    assign len_in    = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
    assign count_inc = bytes_q + LEN_W'(1);
    assign waiting   = is_wait_state(state_q);

    // Condition that lets each wait state move on; it wins over a same-cycle timeout.
    always_comb begin
        advance = 1'b0;
        unique case (state_q)
            StPre:   advance = ~drdy_s;
            StReq:   advance = drdy_s;
            StRel:   advance = ~drdy_s;
            default: advance = 1'b0;
        endcase
    end

    assign timed_out = waiting && !advance && (wait_q == TMO_LIMIT);

    // Per-wait cycle counter, restarted on every state change and on timeout.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            wait_q <= '0;
        end else if (waiting && !advance && !timed_out) begin
            wait_q <= wait_q + TMO_W'(1);
        end else begin
            wait_q <= '0;
        end
    end

    // Burst FSM with registered handshake, stream and status outputs.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            bytes_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            dreq_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (timed_out) begin
                terr_q  <= 1'b1;
                dreq_q  <= 1'b0;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            bytes_q <= '0;
                            terr_q  <= 1'b0;
                            if (len_in == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                len_q   <= len_in;
                                busy_q  <= 1'b1;
                                state_q <= StPre;
                            end
                        end
                    end
                    // A drdy still high here is stale (e.g. left over from an abort).
                    StPre: begin
                        if (!drdy_s) begin
                            dreq_q  <= 1'b1;
                            state_q <= StReq;
                        end
                    end
                    // Capture here: the responder clears pmp_d once dreq falls.
                    StReq: begin
                        if (drdy_s) begin
                            data_q  <= pmp_d;
                            dreq_q  <= 1'b0;
                            state_q <= StRel;
                        end
                    end
                    StRel: begin
                        if (!drdy_s) begin
                            valid_q <= 1'b1;
                            state_q <= StHold;
                        end
                    end
                    // Backpressure may stall here indefinitely; no timeout applies.
                    StHold: begin
                        if (byte_ready) begin
                            valid_q <= 1'b0;
                            bytes_q <= count_inc;
                            if (count_inc == len_q) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                state_q <= StPre;
                            end
                        end
                    end
                    default: begin
                        dreq_q  <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign bytes_read  = bytes_q;
    assign pmp_dreq    = dreq_q;
    assign byte_data   = data_q;
    assign byte_valid  = valid_q;

endmodule

// File: tb/tb_pmp_burst_reader.sv
// Self-checking bench for pmp_burst_reader with a behavioural PMP responder.
module tb_pmp_burst_reader;

    localparam int LEN_W = 9;
    localparam int RM_NORMAL = 0;
    localparam int RM_SILENT = 1;
    localparam int RM_STUCK  = 2;

    logic             clk = 1'b0;
    logic             sys_reset;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [LEN_W-1:0] bytes_read;
    logic             pmp_dreq;
    logic             pmp_drdy;
    logic [7:0]       pmp_d;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;

    int checks = 0;
    int errors = 0;

    // Responder / ready-driver controls
    int   resp_mode  = RM_SILENT;
    int   resp_delay = 0;
    int   rdy_mode   = 0;
    logic rdy_manual = 1'b1;
    logic [7:0] resp_q[$];

    // Reference model: bytes expected downstream, in order
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int done_cnt    = 0;
    int dreq_hi_cnt = 0;
    int cyc         = 0;
    int rise_cyc    = 0;
    int fall_cyc    = 0;

    typedef struct {
        int          len;
        int          delay;
        int          rdy;
        logic [31:0] data;
        int          exp_read;
    } vec_t;

    vec_t vecs[5];

    pmp_burst_reader #(
        .BURST_MAX      (256),
        .TIMEOUT_CYCLES (15),
        .SYNC_STAGES    (2)
    ) dut (
        .sys_clock   (clk),
        .sys_reset   (sys_reset),
        .start       (start),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .bytes_read  (bytes_read),
        .pmp_dreq    (pmp_dreq),
        .pmp_drdy    (pmp_drdy),
        .pmp_d       (pmp_d),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Responder: raises drdy resp_delay cycles after seeing dreq, drops it and
    // zeroes data when dreq falls.
    initial begin
        int rcnt;
        rcnt = 0;
        pmp_drdy = 1'b0;
        pmp_d = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (resp_mode == RM_STUCK) begin
                pmp_drdy = 1'b1;
                pmp_d = 8'h77;
            end else if (resp_mode == RM_SILENT || !pmp_dreq) begin
                pmp_drdy = 1'b0;
                pmp_d = 8'h00;
                rcnt = 0;
            end else if (!pmp_drdy) begin
                if (rcnt >= resp_delay) begin
                    pmp_d = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
                    pmp_drdy = 1'b1;
                end else begin
                    rcnt++;
                end
            end
        end
    end

    // Downstream ready driver
    initial begin
        byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) byte_ready = 1'b1;
            else if (rdy_mode == 1) byte_ready = 1'($urandom_range(0, 1));
            else byte_ready = rdy_manual;
        end
    end

    // Monitor: collects handed-off bytes, done pulses and dreq activity
    initial begin
        logic dreq_prev;
        dreq_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!sys_reset) begin
                if (byte_valid && byte_ready) got_q.push_back(byte_data);
                if (done) done_cnt++;
            end
            if (pmp_dreq) dreq_hi_cnt++;
            if (pmp_dreq && !dreq_prev) rise_cyc = cyc;
            if (!pmp_dreq && dreq_prev) fall_cyc = cyc;
            dreq_prev = pmp_dreq;
        end
    end

    // Global time limit
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] b);
        resp_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic start_burst(input int len);
        got_q.delete();
        burst_len = len[LEN_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (done_cnt != d0) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s wait_done: got no done within %0d cycles, want done", tag, bound);
    endtask

    task automatic check_got(input string tag);
        int n;
        chk({tag, " nbytes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic finish_burst(input int d0, input int exp_read, input string tag);
        wait_done(d0, 3000, tag);
        tick();
        tick();
        chk({tag, " done_pulses"}, done_cnt - d0, 1);
        chk({tag, " bytes_read"}, bytes_read, exp_read);
        chk({tag, " timeout_err"}, timeout_err, 0);
        chk({tag, " busy"}, busy, 0);
        check_got(tag);
        rdy_mode = 0;
    endtask

    task automatic run_burst(input int len, input int delay, input int rdy, input string tag);
        int d0;
        resp_mode  = RM_NORMAL;
        resp_delay = delay;
        rdy_mode   = rdy;
        d0 = done_cnt;
        start_burst(len);
        chk({tag, " busy_after_start"}, busy, 1);
        finish_burst(d0, len, tag);
    endtask

    initial begin
        int d0;
        int dh0;
        int len;
        bit seen;

        vecs[0] = '{3, 3, 0, 32'h00FF3CA5, 3};
        vecs[1] = '{1, 0, 0, 32'h0000005A, 1};
        vecs[2] = '{4, 1, 1, 32'h11223344, 4};
        vecs[3] = '{2, 5, 1, 32'h00008001, 2};
        vecs[4] = '{4, 0, 1, 32'hDEADBEEF, 4};

        sys_reset = 1'b1;
        start = 1'b0;
        burst_len = '0;
        repeat (3) tick();

        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst timeout_err", timeout_err, 0);
        chk("rst bytes_read", bytes_read, 0);
        chk("rst pmp_dreq", pmp_dreq, 0);
        chk("rst byte_data", byte_data, 0);
        chk("rst byte_valid", byte_valid, 0);

        sys_reset = 1'b0;
        resp_mode = RM_NORMAL;
        tick();
        tick();

        // Table-driven bursts
        for (int v = 0; v < 5; v++) begin
            logic [31:0] w;
            w = vecs[v].data;
            for (int i = 0; i < vecs[v].len; i++) push_byte(w[8*i +: 8]);
            resp_mode  = RM_NORMAL;
            resp_delay = vecs[v].delay;
            rdy_mode   = vecs[v].rdy;
            d0 = done_cnt;
            start_burst(vecs[v].len);
            chk($sformatf("vec%0d busy_after_start", v), busy, 1);
            finish_burst(d0, vecs[v].exp_read, $sformatf("vec%0d", v));
        end

        // Zero-length burst: done next cycle, no request
        d0 = done_cnt;
        dh0 = dreq_hi_cnt;
        start_burst(0);
        chk("len0 done", done, 1);
        chk("len0 busy", busy, 0);
        tick();
        chk("len0 done_low", done, 0);
        chk("len0 done_pulses", done_cnt - d0, 1);
        chk("len0 bytes_read", bytes_read, 0);
        chk("len0 no_dreq", dreq_hi_cnt - dh0, 0);

        // Silent responder: REQ times out 16 cycles after dreq rises
        resp_mode = RM_SILENT;
        d0 = done_cnt;
        start_burst(2);
        wait_done(d0, 200, "tmo");
        tick();
        tick();
        chk("tmo timeout_err", timeout_err, 1);
        chk("tmo bytes_read", bytes_read, 0);
        chk("tmo busy", busy, 0);
        chk("tmo pmp_dreq", pmp_dreq, 0);
        chk("tmo done_pulses", done_cnt - d0, 1);
        chk("tmo dreq_width", fall_cyc - rise_cyc, 16);
        chk("tmo nbytes", got_q.size(), 0);
        resp_mode = RM_NORMAL;

        // Backpressure on byte 2 of 4, plus an ignored start while busy
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        push_byte(8'hC4);
        resp_delay = 2;
        rdy_mode = 2;
        rdy_manual = 1'b1;
        d0 = done_cnt;
        start_burst(4);
        chk("bp timeout_cleared", timeout_err, 0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (got_q.size() >= 1) seen = 1'b1;
            else tick();
        end
        rdy_manual = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (byte_valid) seen = 1'b1;
        end
        chk("bp byte2_valid", byte_valid, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                burst_len = 9'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            chk($sformatf("bp stall%0d data", i), byte_data, 8'hC2);
            chk($sformatf("bp stall%0d valid", i), byte_valid, 1);
            chk($sformatf("bp stall%0d dreq", i), pmp_dreq, 0);
        end
        start = 1'b0;
        rdy_manual = 1'b1;
        finish_burst(d0, 4, "bp");
        rdy_mode = 0;

        // drdy stuck high at start: held in PRE with no request, then resumes
        resp_mode = RM_STUCK;
        repeat (3) tick();
        push_byte(8'h6B);
        push_byte(8'h94);
        dh0 = dreq_hi_cnt;
        d0 = done_cnt;
        start_burst(2);
        repeat (8) tick();
        chk("stuck no_dreq", dreq_hi_cnt - dh0, 0);
        chk("stuck busy", busy, 1);
        chk("stuck no_done", done_cnt - d0, 0);
        resp_mode = RM_NORMAL;
        resp_delay = 1;
        finish_burst(d0, 2, "stuck_release");

        // drdy stuck long enough for PRE to time out
        resp_mode = RM_STUCK;
        repeat (3) tick();
        dh0 = dreq_hi_cnt;
        d0 = done_cnt;
        start_burst(1);
        wait_done(d0, 100, "pre_tmo");
        tick();
        chk("pre_tmo timeout_err", timeout_err, 1);
        chk("pre_tmo no_dreq", dreq_hi_cnt - dh0, 0);
        chk("pre_tmo bytes_read", bytes_read, 0);
        resp_mode = RM_NORMAL;
        tick();
        tick();

        // Asynchronous reset while in REQ
        resp_mode = RM_NORMAL;
        resp_delay = 10;
        resp_q.push_back(8'hEE);
        start_burst(2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (pmp_dreq) seen = 1'b1;
            else tick();
        end
        chk("rstreq dreq_before", pmp_dreq, 1);
        #3;
        sys_reset = 1'b1;
        #1;
        chk("rstreq pmp_dreq", pmp_dreq, 0);
        chk("rstreq busy", busy, 0);
        chk("rstreq byte_valid", byte_valid, 0);
        chk("rstreq bytes_read", bytes_read, 0);
        chk("rstreq done", done, 0);
        chk("rstreq timeout_err", timeout_err, 0);
        tick();
        tick();
        sys_reset = 1'b0;
        resp_q.delete();
        exp_q.delete();
        tick();
        push_byte(8'h3D);
        push_byte(8'hD3);
        run_burst(2, 1, 0, "post_reset");

        // Randomized bursts against the reference queue
        for (int n = 0; n < 20; n++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) push_byte(8'($urandom));
            run_burst(len, $urandom_range(0, 5), $urandom_range(0, 1), $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
